tx_lane_sched: RTL and testbench
================================

TX_LANE_SCHED -- requirements
Module: tx_lane_sched

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per packet (2..255).
REQ-002 SHALL have parameter SKP_INT, default 64, cycles between SKP ordered-set requests (>=8).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports req0/req1, input, 1 bit each: source 0/1 has a packet ready.
REQ-006 SHALL have ports data0/data1, input, 8 bits each: current payload byte of source 0/1.
REQ-007 SHALL have ports last0/last1, input, 1 bit each: the current byte is the final byte of the packet.
REQ-008 SHALL have ports gnt0/gnt1, output, 1 bit each, registered: source owns the lane; never both high.
REQ-009 SHALL have ports pop0/pop1, output, 1 bit each, combinational: the current byte is consumed at the next edge; source advances after it.
REQ-010 SHALL have port DATA, output, 8 bits, registered: lane byte.
REQ-011 SHALL have port K, output, 1 bit, registered: DATA is a control symbol.
REQ-012 SHALL have port Valid, output, 1 bit, registered: lane active.
REQ-013 SHALL have port trunc, output, 1 bit, registered: one-cycle pulse when a packet is cut at MAX_LEN.

Function
REQ-014 SHALL implement FSM states IDLE, PAY, END, SKP; registered outputs reflect the state transition taken at each edge.
REQ-015 SHALL, in IDLE with skp_pending=1: emit DATA=0xBC K=1, clear skp_pending, and go to SKP with skp_cnt=0.
REQ-016 SHALL, in IDLE with no SKP pending and any req: emit DATA=0xBC K=1, set the chosen gnt, clear pay_cnt, and go to PAY.
REQ-017 SHALL, in IDLE with nothing pending: emit DATA=0x7C K=1 and stay in IDLE.
REQ-018 SHALL give SKP priority over a waiting req.
REQ-019 SHALL arbitrate round-robin: a 1-bit pointer selects the preferred source; a lone requester always wins; the pointer resets to source 0.
REQ-020 SHALL toggle the pointer to the non-served source at the END edge.
REQ-021 SHALL assert popN = (state==PAY) & gntN.
REQ-022 SHALL, at each PAY edge: emit DATA=dataN K=0 and increment pay_cnt.
REQ-023 SHALL go from PAY to END when lastN=1 or pay_cnt==MAX_LEN-1; otherwise it SHALL stay in PAY.
REQ-024 SHALL, when leaving PAY at pay_cnt==MAX_LEN-1 with lastN=0, pulse trunc=1 with the END symbol; remaining source bytes are the source's responsibility.
REQ-025 SHALL, at the END edge: emit DATA=0xFD K=1, clear gnt, and go to IDLE (no back-to-back COM without an IDLE decision).
REQ-026 SHALL ignore reqN deassertion mid-packet; the packet completes by last or truncation.
REQ-027 SHALL, in SKP: emit DATA=0x1C K=1 for 3 consecutive edges (skp_cnt 0..2), then go to IDLE.
REQ-028 SHALL free-run the SKP timer, counting 0..SKP_INT-1 and wrapping.
REQ-029 SHALL set skp_pending at the wrap; skp_pending is served only from IDLE, so SKP never splits a packet.
REQ-030 SHALL keep a wrap that coincides with a pending SKP as a single pending flag (no queuing).
REQ-031 SHALL hold Valid=1 at every edge after reset release.
REQ-032 SHALL size pay_cnt at 8 bits.

Reset
REQ-033 SHALL, while reset=0, force regardless of CLK: state=IDLE, DATA=0x00, K=0, Valid=0, gnt0=gnt1=0, trunc=0, pointer=0, pay_cnt=0, skp_cnt=0, SKP timer=0, skp_pending=0.
REQ-034 SHALL, on reset asserted mid-packet, abandon the packet without emitting END; after release, the first edge follows IDLE rules.

Verification
REQ-035 SHALL cover: release reset with no req -> DATA=0x7C K=1 Valid=1 each cycle; SKP_INT=64 yields BC,1C,1C,1C after 64 cycles.
REQ-036 SHALL cover: req0 with bytes 25,F9,4F (last on 4F) -> lane BC(K),25,F9,4F,FD(K); pop0 high exactly 3 cycles; gnt0 high BC..4F.
REQ-037 SHALL cover: req0=req1=1 continuously, 2-byte packets -> packets alternate 0,1,0,1, source 0 first; one BC..FD frame per grant.
REQ-038 SHALL cover: MAX_LEN=4, source holds last=0 -> BC,4 payload bytes,FD with trunc=1 on the FD cycle.
REQ-039 SHALL cover: SKP timer wraps during a 10-byte packet -> packet undisturbed; SKP set emitted immediately after FD, before the next BC.
REQ-040 SHALL cover: reset low two cycles into PAY -> outputs zero asynchronously; after release, 7C idle, then the pending req restarts with BC.

Source files
------------

// File: rtl/tx_lane_sched.sv
// tx_lane_sched: two-source packet scheduler for a single 8-bit lane.
// Frames each packet as COM(BC,K) + payload + END(FD,K), fills idle time
// with 7C(K), and inserts BC,1C,1C,1C SKP sets between packets at a fixed
// interval. Sources are arbitrated round-robin.
// Ports:
//   CLK, reset       clock, async active-low reset
//   req0/req1        source has a packet ready
//   data0/data1      current payload byte of each source
//   last0/last1      current byte is the packet's final byte
//   gnt0/gnt1        registered: source owns the lane (one-hot or zero)
//   pop0/pop1        combinational: current byte consumed at next edge
//   DATA, K, Valid   registered lane byte, control flag, lane active
//   trunc            registered one-cycle pulse with FD of a truncated packet
module tx_lane_sched #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned SKP_INT = 64
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       last0,
  input  logic       last1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       pop0,
  output logic       pop1,
  output logic [7:0] DATA,
  output logic       K,
  output logic       Valid,
  output logic       trunc
);

  localparam int unsigned TW = (SKP_INT > 1) ? $clog2(SKP_INT) : 1;
  localparam logic [7:0] SYM_COM  = 8'hBC;
  localparam logic [7:0] SYM_IDL  = 8'h7C;
  localparam logic [7:0] SYM_END  = 8'hFD;
  localparam logic [7:0] SYM_SKP  = 8'h1C;

  typedef enum logic [1:0] {IDLE, PAY, END, SKP} state_t;

  state_t        state, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [7:0]    data_d;
  logic          k_d, trunc_d;
  logic          ptr, ptr_d;
  logic [7:0]    pay_cnt, pay_cnt_d;
  logic [1:0]    skp_cnt, skp_cnt_d;
  logic          skp_pend, skp_pend_d, skp_clr;
  logic          trunc_pend, trunc_pend_d;
  logic [TW-1:0] timer;

  logic          sel, cur_last, at_max, wrap, pick;
  logic [7:0]    cur_data;

  assign sel      = gnt_q[1];
  assign cur_data = sel ? data1 : data0;
  assign cur_last = sel ? last1 : last0;
  assign at_max   = (pay_cnt == 8'(MAX_LEN - 1));
  assign wrap     = (timer == TW'(SKP_INT - 1));
  // Lone requester wins; on contention the pointer decides.
  assign pick     = (req0 & req1) ? ptr : req1;

  assign gnt0 = gnt_q[0];
  assign gnt1 = gnt_q[1];
  assign pop0 = (state == PAY) & gnt_q[0];
  assign pop1 = (state == PAY) & gnt_q[1];

  // Next-state and next-output decode.
  always_comb begin
    state_d      = state;
    gnt_d        = gnt_q;
    data_d       = DATA;
    k_d          = K;
    trunc_d      = 1'b0;
    ptr_d        = ptr;
    pay_cnt_d    = pay_cnt;
    skp_cnt_d    = skp_cnt;
    skp_clr      = 1'b0;
    trunc_pend_d = trunc_pend;
    case (state)
      IDLE: begin
        k_d = 1'b1;
        if (skp_pend) begin
          data_d    = SYM_COM;
          skp_clr   = 1'b1;
          skp_cnt_d = 2'd0;
          state_d   = SKP;
        end else if (req0 | req1) begin
          data_d       = SYM_COM;
          gnt_d        = pick ? 2'b10 : 2'b01;
          pay_cnt_d    = 8'd0;
          trunc_pend_d = 1'b0;
          state_d      = PAY;
        end else begin
          data_d = SYM_IDL;
        end
      end
      PAY: begin
        data_d    = cur_data;
        k_d       = 1'b0;
        pay_cnt_d = pay_cnt + 8'd1;
        if (cur_last | at_max) begin
          trunc_pend_d = ~cur_last;
          state_d      = END;
        end
      end
      END: begin
        data_d  = SYM_END;
        k_d     = 1'b1;
        gnt_d   = 2'b00;
        trunc_d = trunc_pend;
        ptr_d   = ~sel;
        state_d = IDLE;
      end
      SKP: begin
        data_d    = SYM_SKP;
        k_d       = 1'b1;
        skp_cnt_d = skp_cnt + 2'd1;
        if (skp_cnt == 2'd2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A wrap while a SKP is already pending collapses into the one flag.
    skp_pend_d = wrap | (skp_pend & ~skp_clr);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gnt_q      <= 2'b00;
      DATA       <= 8'h00;
      K          <= 1'b0;
      Valid      <= 1'b0;
      trunc      <= 1'b0;
      ptr        <= 1'b0;
      pay_cnt    <= 8'd0;
      skp_cnt    <= 2'd0;
      skp_pend   <= 1'b0;
      trunc_pend <= 1'b0;
      timer      <= '0;
    end else begin
      state      <= state_d;
      gnt_q      <= gnt_d;
      DATA       <= data_d;
      K          <= k_d;
      Valid      <= 1'b1;
      trunc      <= trunc_d;
      ptr        <= ptr_d;
      pay_cnt    <= pay_cnt_d;
      skp_cnt    <= skp_cnt_d;
      skp_pend   <= skp_pend_d;
      trunc_pend <= trunc_pend_d;
      timer      <= wrap ? '0 : timer + TW'(1);
    end
  end

endmodule

// File: tb/tb_tx_lane_sched.sv
// Bench for tx_lane_sched: directed tables, hand sequences and a randomized
// run against a transaction-level lane model (expected symbol queue).
module tb_tx_lane_sched;

  localparam int unsigned ML_A = 16;
  localparam int unsigned ML_B = 4;
  localparam int unsigned SKP  = 64;

  logic       CLK = 1'b0;
  logic       reset;
  logic       req0, req1, last0, last1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, pop0, pop1, K, Valid, trunc;
  logic [7:0] DATA;

  logic       b_req0, b_req1, b_last0, b_last1;
  logic [7:0] b_data0, b_data1;
  logic       b_gnt0, b_gnt1, b_pop0, b_pop1, b_K, b_Valid, b_trunc;
  logic [7:0] b_DATA;

  always #5 CLK = ~CLK;

  tx_lane_sched #(.MAX_LEN(ML_A), .SKP_INT(SKP)) u_a (
    .CLK(CLK), .reset(reset), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .last0(last0), .last1(last1), .gnt0(gnt0), .gnt1(gnt1), .pop0(pop0), .pop1(pop1),
    .DATA(DATA), .K(K), .Valid(Valid), .trunc(trunc));

  tx_lane_sched #(.MAX_LEN(ML_B), .SKP_INT(SKP)) u_b (
    .CLK(CLK), .reset(reset), .req0(b_req0), .req1(b_req1), .data0(b_data0), .data1(b_data1),
    .last0(b_last0), .last1(b_last1), .gnt0(b_gnt0), .gnt1(b_gnt1), .pop0(b_pop0), .pop1(b_pop1),
    .DATA(b_DATA), .K(b_K), .Valid(b_Valid), .trunc(b_trunc));

  int passed, total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [7:0] d;
    logic       k;
    logic [1:0] g;
    logic       tr;
    logic       pay;
  } sym_t;

  sym_t       expq[$];
  bit         pend;
  bit         pref;
  int         edge_n;
  logic [7:0] sb[2][32];
  int         sl[2], si[2];
  bit         sa[2];

  task automatic push(input logic [7:0] d, input logic k, input logic [1:0] g,
                      input logic tr, input logic pay);
    sym_t s;
    s.d = d; s.k = k; s.g = g; s.tr = tr; s.pay = pay;
    expq.push_back(s);
  endtask

  // What the lane emits from the next idle decision point onwards.
  task automatic decide();
    int s, n;
    logic [1:0] gv;
    if (pend) begin
      push(8'hBC, 1'b1, 2'b00, 1'b0, 1'b0);
      repeat (3) push(8'h1C, 1'b1, 2'b00, 1'b0, 1'b0);
      pend = 1'b0;
    end else if (sa[0] || sa[1]) begin
      s  = (sa[0] && sa[1]) ? int'(pref) : (sa[0] ? 0 : 1);
      n  = (sl[s] < int'(ML_A)) ? sl[s] : int'(ML_A);
      gv = (s == 1) ? 2'b10 : 2'b01;
      push(8'hBC, 1'b1, gv, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) push(sb[s][i], 1'b0, gv, 1'b0, 1'b1);
      push(8'hFD, 1'b1, 2'b00, sl[s] > int'(ML_A), 1'b0);
      pref = (s == 0);
    end else begin
      push(8'h7C, 1'b1, 2'b00, 1'b0, 1'b0);
    end
  endtask

  task automatic load(input int s, input int len);
    for (int i = 0; i < len; i++) sb[s][i] = 8'($urandom);
    sl[s] = len; si[s] = 0; sa[s] = 1'b1;
  endtask

  task automatic drive_src();
    req0  = sa[0];
    data0 = sa[0] ? sb[0][si[0]] : 8'h00;
    last0 = sa[0] && (si[0] == sl[0] - 1);
    req1  = sa[1];
    data1 = sa[1] ? sb[1][si[1]] : 8'h00;
    last1 = sa[1] && (si[1] == sl[1] - 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0 = 0; req1 = 0; last0 = 0; last1 = 0; data0 = 0; data1 = 0;
    b_req0 = 0; b_req1 = 0; b_last0 = 0; b_last1 = 0; b_data0 = 0; b_data1 = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    expq.delete();
    pend = 0; pref = 0; edge_n = 0;
    for (int s = 0; s < 2; s++) begin sa[s] = 0; si[s] = 0; sl[s] = 0; end
  endtask

  // mode 0: no traffic, 1: both sources back-to-back 2-byte packets,
  // 2: one 10-byte packet straddling the SKP wrap, 3: random traffic.
  task automatic run_model(input int ncyc, input int mode);
    sym_t e;
    logic [1:0] p;
    for (int c = 0; c < ncyc; c++) begin
      case (mode)
        1: for (int s = 0; s < 2; s++) if (!sa[s]) load(s, 2);
        2: if (edge_n == 55 && !sa[0]) load(0, 10);
        3: for (int s = 0; s < 2; s++)
             if (!sa[s] && $urandom_range(0, 3) == 0) load(s, int'($urandom_range(1, 20)));
        default: ;
      endcase
      drive_src();
      if (expq.size() == 0) decide();
      e = expq[0];
      p = {pop1, pop0};
      chk("pop", 32'(p), 32'(e.pay ? e.g : 2'b00));
      @(posedge CLK); #1;
      edge_n++;
      e = expq.pop_front();
      chk("lane {valid,trunc,gnt1,gnt0,k,data}", 32'({Valid, trunc, gnt1, gnt0, K, DATA}),
          32'({1'b1, e.tr, e.g, e.k, e.d}));
      if (edge_n % int'(SKP) == 0) pend = 1'b1;
      for (int s = 0; s < 2; s++)
        if (p[s] && sa[s]) begin
          if (si[s] == sl[s] - 1 || si[s] == int'(ML_A) - 1) sa[s] = 1'b0;
          else si[s]++;
        end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       req;
    logic [7:0] d;
    logic       l;
    logic       pop;
    logic [7:0] xd;
    logic       xk;
    logic       xg;
  } rec_t;

  rec_t tbl[7];

  initial begin
    passed = 0; total = 0;
    reset = 1'b0;
    req0 = 0; req1 = 0; last0 = 0; last1 = 0; data0 = 0; data1 = 0;
    b_req0 = 0; b_req1 = 0; b_last0 = 0; b_last1 = 0; b_data0 = 0; b_data1 = 0;
    #12;
    chk("reset a", 32'({Valid, trunc, gnt1, gnt0, pop1, pop0, K, DATA}), 32'd0);
    chk("reset b", 32'({b_Valid, b_trunc, b_gnt1, b_gnt0, b_pop1, b_pop0, b_K, b_DATA}), 32'd0);

    // Single 3-byte packet; req0 dropped mid-packet must be ignored.
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h7C, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'hBC, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 8'h25, 1'b0, 1'b1, 8'h25, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'hF9, 1'b0, 1'b1, 8'hF9, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'h4F, 1'b1, 1'b1, 8'h4F, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hFD, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h7C, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      req0 = tbl[i].req; data0 = tbl[i].d; last0 = tbl[i].l;
      chk($sformatf("tbl[%0d] pop0", i), 32'(pop0), 32'(tbl[i].pop));
      @(posedge CLK); #1;
      chk($sformatf("tbl[%0d] {valid,trunc,gnt1,gnt0,k,data}", i),
          32'({Valid, trunc, gnt1, gnt0, K, DATA}),
          32'({1'b1, 1'b0, 1'b0, tbl[i].xg, tbl[i].xk, tbl[i].xd}));
    end

    // Truncation at MAX_LEN=4 with last never asserted.
    b_req0 = 1; b_last0 = 0; b_data0 = 8'hA0;
    chk("trunc pop before COM", 32'(b_pop0), 32'd0);
    @(posedge CLK); #1;
    chk("trunc COM", 32'({b_trunc, b_gnt0, b_K, b_DATA}), 32'({1'b0, 1'b1, 1'b1, 8'hBC}));
    for (int i = 0; i < 4; i++) begin
      b_data0 = 8'(8'hA0 + i);
      chk($sformatf("trunc pop[%0d]", i), 32'(b_pop0), 32'd1);
      @(posedge CLK); #1;
      chk($sformatf("trunc byte[%0d]", i), 32'({b_trunc, b_gnt0, b_K, b_DATA}),
          32'({1'b0, 1'b1, 1'b0, 8'(8'hA0 + i)}));
    end
    b_req0 = 0;
    chk("trunc pop at END", 32'(b_pop0), 32'd0);
    @(posedge CLK); #1;
    chk("trunc END", 32'({b_trunc, b_gnt0, b_K, b_DATA}), 32'({1'b1, 1'b0, 1'b1, 8'hFD}));
    @(posedge CLK); #1;
    chk("trunc pulse ends", 32'({b_trunc, b_gnt0, b_K, b_DATA}), 32'({1'b0, 1'b0, 1'b1, 8'h7C}));

    // Model-checked scenarios.
    do_reset(); run_model(75, 0);
    do_reset(); run_model(60, 1);
    do_reset(); run_model(80, 2);
    do_reset(); run_model(3000, 3);

    // Reset asserted two cycles into PAY.
    do_reset();
    req0 = 1; data0 = 8'h11; last0 = 0;
    @(posedge CLK); #1;
    chk("rst-mid COM", 32'({gnt0, K, DATA}), 32'({1'b1, 1'b1, 8'hBC}));
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("rst-mid pay", 32'({gnt0, K, DATA}), 32'({1'b1, 1'b0, 8'h11}));
    #2 reset = 1'b0;
    #1;
    chk("rst-mid async clear", 32'({Valid, trunc, gnt1, gnt0, pop1, pop0, K, DATA}), 32'd0);
    req0 = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    @(posedge CLK); #1;
    chk("rst-mid idle", 32'({Valid, gnt0, K, DATA}), 32'({1'b1, 1'b0, 1'b1, 8'h7C}));
    req0 = 1; data0 = 8'h22; last0 = 1;
    @(posedge CLK); #1;
    chk("rst-mid restart COM", 32'({gnt0, K, DATA}), 32'({1'b1, 1'b1, 8'hBC}));
    chk("rst-mid restart pop", 32'(pop0), 32'd1);
    @(posedge CLK); #1;
    chk("rst-mid restart byte", 32'({gnt0, K, DATA}), 32'({1'b1, 1'b0, 8'h22}));
    req0 = 0; last0 = 0;
    @(posedge CLK); #1;
    chk("rst-mid restart END", 32'({trunc, gnt0, K, DATA}), 32'({1'b0, 1'b0, 1'b1, 8'hFD}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
